// File: rtl/frame_scanout_reader.sv
// frame_scanout_reader: per-line SRAM row fetch into a ping-pong line buffer feeding 4-bit palette indices.
// Define SCANOUT_DOUBLE_SCAN_EN for 320x240 mode (half-height rows, half-length fetch, 2x2 pixel replication).
module frame_scanout_reader #(
    parameter int WORDS_PER_LINE = 160,
    parameter int READ_WAIT      = 2
) (
    input  logic        Clk,
    input  logic        Reset_N,
    input  logic        even_frame,
    input  logic        line_start,
    input  logic [9:0]  next_row,
    input  logic [9:0]  DrawX,
    output logic [3:0]  pixel_index,
    output logic        sram_req,
    input  logic        sram_grant,
    output logic [19:0] SRAM_ADDRESS,
    output logic        SRAM_OE_N,
    input  logic [15:0] Data_from_SRAM,
    output logic        fetch_busy,
    output logic        fetch_overrun
);
    typedef enum logic [2:0] {IDLE, REQ, READ, CAPTURE, GAP} state_t;

    localparam int WW = $clog2(READ_WAIT + 1);
    localparam logic [9:0] PIX_LIMIT = 10'(4 * WORDS_PER_LINE);

    state_t          r_state;
    logic [7:0]      r_word;
    logic [WW-1:0]   r_wait;
    logic [9:0]      r_row;
    logic            r_frame_sel;
    logic            r_front;
    logic [15:0]     r_buf [0:1][0:WORDS_PER_LINE-1];

    logic [9:0]      w_row;
    logic [7:0]      w_word_idx;
    logic [1:0]      w_nib;
    logic [7:0]      w_last;
    logic [19:0]     w_addr;
    logic [15:0]     w_front_word;
    logic            w_wr;

`ifdef SCANOUT_DOUBLE_SCAN_EN
    assign w_row      = {1'b0, next_row[9:1]};
    assign w_word_idx = {1'b0, DrawX[9:3]};
    assign w_nib      = DrawX[2:1];
    assign w_last     = 8'(WORDS_PER_LINE / 2 - 1);
`else
    assign w_row      = next_row;
    assign w_word_idx = DrawX[9:2];
    assign w_nib      = DrawX[1:0];
    assign w_last     = 8'(WORDS_PER_LINE - 1);
`endif

    assign w_addr       = {1'b0, r_frame_sel, r_row, r_word};
    assign w_front_word = r_buf[r_front][w_word_idx];
    // A capture coinciding with line_start belongs to the abandoned fetch, so it is dropped.
    assign w_wr         = (r_state == CAPTURE) && sram_grant && !line_start;

    // Fetch FSM: requests the bus, reads one word per grant, yields the bus for one cycle between words.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state       <= IDLE;
            r_word        <= '0;
            r_wait        <= '0;
            r_row         <= '0;
            r_frame_sel   <= 1'b0;
            r_front       <= 1'b0;
            sram_req      <= 1'b0;
            SRAM_OE_N     <= 1'b1;
            SRAM_ADDRESS  <= '0;
            fetch_busy    <= 1'b0;
            fetch_overrun <= 1'b0;
        end else if (line_start) begin
            r_front     <= ~r_front;
            r_frame_sel <= even_frame;
            r_row       <= w_row;
            r_word      <= '0;
            r_wait      <= '0;
            r_state     <= REQ;
            sram_req    <= 1'b1;
            SRAM_OE_N   <= 1'b1;
            fetch_busy  <= 1'b1;
            if (fetch_busy)
                fetch_overrun <= 1'b1;
        end else begin
            case (r_state)
                IDLE: ;
                REQ: if (sram_grant) begin
                    r_state      <= READ;
                    r_wait       <= '0;
                    SRAM_OE_N    <= 1'b0;
                    SRAM_ADDRESS <= w_addr;
                end
                READ: if (!sram_grant) begin
                    r_state   <= REQ;
                    SRAM_OE_N <= 1'b1;
                end else if (r_wait == WW'(READ_WAIT - 1)) begin
                    r_state <= CAPTURE;
                end else begin
                    r_wait <= r_wait + 1'b1;
                end
                CAPTURE: if (!sram_grant) begin
                    r_state   <= REQ;
                    SRAM_OE_N <= 1'b1;
                end else if (r_word == w_last) begin
                    r_state    <= IDLE;
                    sram_req   <= 1'b0;
                    SRAM_OE_N  <= 1'b1;
                    fetch_busy <= 1'b0;
                end else begin
                    r_word    <= r_word + 1'b1;
                    r_state   <= GAP;
                    sram_req  <= 1'b0;
                    SRAM_OE_N <= 1'b1;
                end
                GAP: begin
                    r_state  <= REQ;
                    sram_req <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Line buffer write: captured SRAM word lands in the back buffer.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            for (int b = 0; b < 2; b++)
                for (int w = 0; w < WORDS_PER_LINE; w++)
                    r_buf[b][w] <= '0;
        end else if (w_wr) begin
            r_buf[~r_front][r_word] <= Data_from_SRAM;
        end
    end

    // Pixel lookup from the front buffer; columns past the fetched line show index 0.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N)
            pixel_index <= '0;
        else
            pixel_index <= (DrawX >= PIX_LIMIT) ? 4'd0 : w_front_word[{w_nib, 2'b00} +: 4];
    end
endmodule

// File: tb/tb_frame_scanout_reader.sv
// tb_frame_scanout_reader: randomized bench with a behavioural line-buffer / SRAM model.
module tb_frame_scanout_reader;
    localparam int WPL = 160;
    localparam int RW  = 2;
`ifdef SCANOUT_DOUBLE_SCAN_EN
    localparam int NW = WPL / 2;
    localparam bit DS = 1'b1;
`else
    localparam int NW = WPL;
    localparam bit DS = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset_N;
    logic        even_frame;
    logic        line_start;
    logic [9:0]  next_row;
    logic [9:0]  DrawX;
    logic [3:0]  pixel_index;
    logic        sram_req;
    logic        sram_grant;
    logic [19:0] SRAM_ADDRESS;
    logic        SRAM_OE_N;
    logic [15:0] Data_from_SRAM;
    logic        fetch_busy;
    logic        fetch_overrun;

    frame_scanout_reader #(.WORDS_PER_LINE(WPL), .READ_WAIT(RW)) dut (
        .Clk(Clk), .Reset_N(Reset_N), .even_frame(even_frame), .line_start(line_start),
        .next_row(next_row), .DrawX(DrawX), .pixel_index(pixel_index), .sram_req(sram_req),
        .sram_grant(sram_grant), .SRAM_ADDRESS(SRAM_ADDRESS), .SRAM_OE_N(SRAM_OE_N),
        .Data_from_SRAM(Data_from_SRAM), .fetch_busy(fetch_busy), .fetch_overrun(fetch_overrun)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int unsigned salt;

    logic [15:0] model_buf [0:1][0:WPL-1];
    bit          model_front;
    bit          exp_ovr;
    bit          cur_frame;
    int          cur_row;

    typedef struct {logic [19:0] addr; int len;} acc_t;
    acc_t        acc_q[$];
    bit          in_run;
    logic [19:0] run_addr;
    int          run_len;
    int          gap_cnt;
    int          rst_access;

    function automatic logic [15:0] mem_at(input logic [19:0] a);
        int unsigned h;
        if (a % 256 == 0) return 16'h4321;
        h = (32'(a) ^ salt) * 32'h9E3779B1;
        return 16'(h >> 16);
    endfunction

    assign Data_from_SRAM = mem_at(SRAM_ADDRESS);

    function automatic logic [19:0] exp_addr(input int k);
        return 20'(cur_frame * (1 << 18) + cur_row * 256 + k);
    endfunction

    function automatic logic [3:0] model_px(input int x);
        logic [15:0] d;
        int w, n;
        if (x >= 4 * WPL) return 4'd0;
        w = DS ? x / 8 : x / 4;
        n = DS ? (x / 2) % 4 : x % 4;
        d = model_buf[model_front][w];
        return 4'((d >> (4 * n)) % 16);
    endfunction

    // Deduplicated access sequence vs. expected word order; -1 when it matches.
    function automatic int seq_bad();
        int k = 0;
        for (int i = 0; i < acc_q.size(); i++) begin
            if (i + 1 < acc_q.size() && acc_q[i + 1].addr == acc_q[i].addr) continue;
            if (k >= NW || acc_q[i].addr != exp_addr(k) || acc_q[i].len != RW + 1) return k;
            k++;
        end
        return (k == NW) ? -1 : k;
    endfunction

    // Bus monitor: records each OE_N-low run as {address, length} and counts bus-yield cycles.
    always @(negedge Clk) begin
        if (!Reset_N && (!SRAM_OE_N || sram_req)) rst_access++;
        if (!SRAM_OE_N) begin
            if (in_run && run_addr == SRAM_ADDRESS) begin
                run_len++;
            end else begin
                if (in_run) acc_q.push_back('{addr: run_addr, len: run_len});
                in_run = 1'b1;
                run_addr = SRAM_ADDRESS;
                run_len = 1;
            end
        end else if (in_run) begin
            acc_q.push_back('{addr: run_addr, len: run_len});
            in_run = 1'b0;
        end
        if (fetch_busy && !sram_req) gap_cnt++;
    end

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int w = 0; w < WPL; w++)
                model_buf[b][w] = '0;
        model_front = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic model_fill(input int n);
        for (int w = 0; w < n; w++)
            model_buf[~model_front][w] = mem_at(exp_addr(w));
    endtask

    task automatic pulse_line(input bit frame, input int row, input bit abandon);
        @(negedge Clk);
        even_frame = frame;
        next_row = 10'(row);
        line_start = 1'b1;
        @(negedge Clk);
        #1;
        line_start = 1'b0;
        even_frame = ~frame;
        next_row = 10'($urandom_range(479, 0));
        if (abandon) exp_ovr = 1'b1;
        model_front = ~model_front;
        cur_frame = frame;
        cur_row = DS ? row / 2 : row;
        acc_q.delete();
        gap_cnt = 0;
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge Clk);
            if (!fetch_busy) begin
                to = 1'b0;
                break;
            end
        end
        @(negedge Clk);
        #1;
    endtask

    task automatic test_reset();
        bit seen = 1'b0;
        repeat (3) @(negedge Clk);
        checks++; if (pixel_index !== 4'd0) begin errors++; $display("FAIL rst_pixel got=%h want=0", pixel_index); end
        checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b want=0", sram_req); end
        checks++; if (SRAM_OE_N !== 1'b1) begin errors++; $display("FAIL rst_oe got=%b want=1", SRAM_OE_N); end
        checks++; if (SRAM_ADDRESS !== 20'd0) begin errors++; $display("FAIL rst_addr got=%h want=0", SRAM_ADDRESS); end
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", fetch_busy); end
        checks++; if (fetch_overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr got=%b want=0", fetch_overrun); end
        Reset_N = 1'b1;
        pulse_line(1'b0, 3, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (!SRAM_OE_N) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rst_read_reach got=timeout want=OE_N low"); end
        #2;
        Reset_N = 1'b0;
        rst_access = 0;
        #1;
        checks++; if (SRAM_OE_N !== 1'b1) begin errors++; $display("FAIL rst_async_oe got=%b want=1", SRAM_OE_N); end
        checks++; if (sram_req !== 1'b0) begin errors++; $display("FAIL rst_async_req got=%b want=0", sram_req); end
        repeat (4) @(negedge Clk);
        checks++; if (rst_access !== 0) begin errors++; $display("FAIL rst_no_access got=%0d want=0", rst_access); end
        Reset_N = 1'b1;
        model_reset();
        @(negedge Clk);
        checks++; if (pixel_index !== 4'd0) begin errors++; $display("FAIL rst_rel_pixel got=%h want=0", pixel_index); end
        checks++; if (fetch_overrun !== 1'b0) begin errors++; $display("FAIL rst_rel_ovr got=%b want=0", fetch_overrun); end
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL rst_rel_busy got=%b want=0", fetch_busy); end
    endtask

    task automatic test_fetch();
        bit to;
        int bad;
        pulse_line(1'b1, 5, 1'b0);
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL fetch_done got=busy want=idle"); end
        checks++; if (acc_q.size() == 0 || acc_q[0].addr !== exp_addr(0)) begin errors++; $display("FAIL fetch_first_addr got=%h want=%h", acc_q.size() ? acc_q[0].addr : 20'hx, exp_addr(0)); end
        checks++; if (acc_q.size() == 0 || acc_q[0].len !== RW + 1) begin errors++; $display("FAIL fetch_oe_len got=%0d want=%0d", acc_q.size() ? acc_q[0].len : -1, RW + 1); end
        checks++; if (acc_q.size() == 0 || acc_q[acc_q.size() - 1].addr !== exp_addr(NW - 1)) begin errors++; $display("FAIL fetch_last_addr got=%h want=%h", acc_q.size() ? acc_q[acc_q.size() - 1].addr : 20'hx, exp_addr(NW - 1)); end
        bad = seq_bad();
        checks++; if (bad !== -1) begin errors++; $display("FAIL fetch_sequence got=bad_word_%0d want=all_%0d_words", bad, NW); end
        checks++; if (gap_cnt !== NW - 1) begin errors++; $display("FAIL fetch_gaps got=%0d want=%0d", gap_cnt, NW - 1); end
        checks++; if (fetch_overrun !== 1'b0) begin errors++; $display("FAIL fetch_ovr got=%b want=0", fetch_overrun); end
        model_fill(NW);
    endtask

    task automatic test_pixels();
        bit to;
        int bad;
        int prev = -1;
        int xs[$] = '{0, 1, 2, 3, 640, 1023};
        repeat (200) xs.push_back($urandom_range(700, 0));
        pulse_line(1'($urandom), $urandom_range(479, 0), 1'b0);
        foreach (xs[i]) begin
            @(negedge Clk);
            if (prev >= 0) begin
                checks++; if (pixel_index !== model_px(prev)) begin errors++; $display("FAIL pixel x=%0d got=%h want=%h", prev, pixel_index, model_px(prev)); end
            end
            DrawX = 10'(xs[i]);
            prev = xs[i];
        end
        @(negedge Clk);
        checks++; if (pixel_index !== model_px(prev)) begin errors++; $display("FAIL pixel x=%0d got=%h want=%h", prev, pixel_index, model_px(prev)); end
        wait_idle(to);
        bad = seq_bad();
        checks++; if (to || bad !== -1) begin errors++; $display("FAIL pixels_fetch got=bad_word_%0d want=complete", bad); end
        model_fill(NW);
    endtask

    task automatic test_grant_drop();
        bit to;
        bit seen = 1'b0;
        int bad;
        int prev = -1;
        pulse_line(1'($urandom), $urandom_range(479, 0), 1'b0);
        for (int i = 0; i < 400; i++) begin
            @(negedge Clk);
            if (!SRAM_OE_N && SRAM_ADDRESS == exp_addr(7)) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL drop_reach got=timeout want=word7_read"); end
        sram_grant = 1'b0;
        repeat (3) @(negedge Clk);
        sram_grant = 1'b1;
        wait_idle(to);
        bad = seq_bad();
        checks++; if (to || bad !== -1) begin errors++; $display("FAIL drop_sequence got=bad_word_%0d want=complete", bad); end
        checks++; if (acc_q.size() !== NW + 1 || acc_q[7].addr !== exp_addr(7) || acc_q[8].addr !== exp_addr(7) || acc_q[7].len >= RW + 1) begin
            errors++; $display("FAIL drop_retry got=runs_%0d want=runs_%0d_with_word7_twice", acc_q.size(), NW + 1);
        end
        checks++; if (gap_cnt !== NW - 1) begin errors++; $display("FAIL drop_gaps got=%0d want=%0d", gap_cnt, NW - 1); end
        model_fill(NW);
        pulse_line(1'($urandom), $urandom_range(479, 0), 1'b0);
        for (int x = 0; x < 4 * WPL; x++) begin
            @(negedge Clk);
            if (prev >= 0) begin
                checks++; if (pixel_index !== model_px(prev)) begin errors++; $display("FAIL drop_buf x=%0d got=%h want=%h", prev, pixel_index, model_px(prev)); end
            end
            DrawX = 10'(x);
            prev = x;
        end
        wait_idle(to);
        model_fill(NW);
    endtask

    task automatic test_overrun();
        bit to;
        bit seen = 1'b0;
        int bad;
        int prev = -1;
        pulse_line(1'($urandom), $urandom_range(479, 0), 1'b0);
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clk);
            if (!SRAM_OE_N && SRAM_ADDRESS == exp_addr(50)) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL ovr_reach got=timeout want=word50_read"); end
        checks++; if (fetch_overrun !== exp_ovr) begin errors++; $display("FAIL ovr_before got=%b want=%b", fetch_overrun, exp_ovr); end
        model_fill(50);
        pulse_line(1'($urandom), $urandom_range(479, 0), 1'b1);
        checks++; if (fetch_overrun !== exp_ovr) begin errors++; $display("FAIL ovr_set got=%b want=%b", fetch_overrun, exp_ovr); end
        for (int x = 0; x < 4 * WPL; x++) begin
            @(negedge Clk);
            if (prev >= 0) begin
                checks++; if (pixel_index !== model_px(prev)) begin errors++; $display("FAIL ovr_stale x=%0d got=%h want=%h", prev, pixel_index, model_px(prev)); end
            end
            DrawX = 10'(x);
            prev = x;
        end
        wait_idle(to);
        bad = seq_bad();
        checks++; if (to || bad !== -1) begin errors++; $display("FAIL ovr_restart got=bad_word_%0d want=complete_from_0", bad); end
        model_fill(NW);
        pulse_line(1'($urandom), $urandom_range(479, 0), 1'b0);
        checks++; if (fetch_overrun !== exp_ovr) begin errors++; $display("FAIL ovr_sticky got=%b want=%b", fetch_overrun, exp_ovr); end
        wait_idle(to);
        model_fill(NW);
    endtask

`ifdef SCANOUT_DOUBLE_SCAN_EN
    task automatic test_double_scan();
        bit to;
        int bad;
        pulse_line(1'b0, 9, 1'b0);
        wait_idle(to);
        bad = seq_bad();
        checks++; if (to || bad !== -1 || cur_row !== 4) begin errors++; $display("FAIL ds_fetch got=bad_word_%0d want=80_words_row4", bad); end
        model_fill(NW);
        pulse_line(1'b1, 0, 1'b0);
        @(negedge Clk); DrawX = 10'd6;
        @(negedge Clk); DrawX = 10'd7;
        checks++; if (pixel_index !== model_px(6)) begin errors++; $display("FAIL ds_x6 got=%h want=%h", pixel_index, model_px(6)); end
        @(negedge Clk);
        checks++; if (pixel_index !== model_px(7)) begin errors++; $display("FAIL ds_x7 got=%h want=%h", pixel_index, model_px(7)); end
        wait_idle(to);
        model_fill(NW);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        salt = $urandom;
        Reset_N = 1'b0;
        line_start = 1'b0;
        even_frame = 1'b0;
        next_row = '0;
        DrawX = '0;
        sram_grant = 1'b1;
        in_run = 1'b0;
        gap_cnt = 0;
        rst_access = 0;
        cur_frame = 1'b0;
        cur_row = 0;
        model_reset();
        test_reset();
        test_fetch();
        test_pixels();
        test_grant_drop();
        test_overrun();
`ifdef SCANOUT_DOUBLE_SCAN_EN
        test_double_scan();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
